// File: rtl/project_select_ctrl.sv
// Wishbone-controlled selector that drives at most one project enable at a time.
// Every change of selection passes through an all-off guard interval.
module project_select_ctrl #(
    parameter int unsigned NUM_PROJECTS = 3,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int unsigned GUARD_CYCLES = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [NUM_PROJECTS-1:0] active,
    output logic                    busy_o
);

    localparam int unsigned CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_ON    = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              cur_id_q, cur_id_d;
    logic [7:0]              pend_id_q, pend_id_d;
    logic                    pend_en_q, pend_en_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [15:0]             sw_cnt_q, sw_cnt_d;
    logic                    ack_q;
    logic [31:0]             dat_q;
    logic [NUM_PROJECTS-1:0] active_q;
    logic                    busy_q;

    logic                    hit_s;
    logic [7:0]              wr_id_s;
    logic                    wr_en_s;
    logic                    id_ok_s;
    logic                    ctrl_wr_s;
    logic                    valid_wr_s;
    logic                    bad_wr_s;
    logic                    same_s;
    logic [31:0]             rdata_s;
    logic [NUM_PROJECTS-1:0] onehot_s;
    logic                    unused_s;

    assign hit_s      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_id_s    = wbs_dat_i[7:0];
    assign wr_en_s    = wbs_dat_i[31];
    assign id_ok_s    = ({1'b0, wr_id_s} < 9'(NUM_PROJECTS));
    // The write is committed at the end of the ack cycle, while the master still holds the request.
    assign ctrl_wr_s  = ack_q & hit_s & wbs_we_i & (wbs_adr_i[3:2] == 2'b00) & (wbs_sel_i == 4'hF);
    assign valid_wr_s = ctrl_wr_s & (~wr_en_s | id_ok_s);
    assign bad_wr_s   = ctrl_wr_s & wr_en_s & ~id_ok_s;
    assign same_s     = wr_en_s & (wr_id_s == cur_id_q);
    assign unused_s   = ^{wbs_adr_i[1:0], wbs_dat_i[30:8]};

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign active     = active_q;
    assign busy_o     = busy_q;

    // Register read mux for the in-window offsets.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (wbs_adr_i[3:2])
            2'b00:   rdata_s = {pend_en_q, 23'd0, pend_id_q};
            2'b01:   rdata_s = {sw_cnt_q, 5'd0, err_q, (state_q == ST_GUARD), (state_q == ST_ON), cur_id_q};
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    // One-hot decode of the next selected project.
    always_comb begin
        onehot_s = '0;
        for (int i = 0; i < int'(NUM_PROJECTS); i++) begin
            onehot_s[i] = (cur_id_d == 8'(i));
        end
    end

    // Next-state logic for selection, guard countdown and error flag.
    always_comb begin
        state_d   = state_q;
        cur_id_d  = cur_id_q;
        pend_id_d = pend_id_q;
        pend_en_d = pend_en_q;
        cnt_d     = cnt_q;
        sw_cnt_d  = sw_cnt_q;
        err_d     = err_q;

        if (bad_wr_s) begin
            err_d = 1'b1;
        end else if (valid_wr_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_OFF: begin
                if (valid_wr_s) begin
                    pend_id_d = wr_id_s;
                    pend_en_d = wr_en_s;
                    if (wr_en_s) begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_GUARD;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_GUARD: begin
                if (valid_wr_s) begin
                    pend_id_d = wr_id_s;
                    pend_en_d = wr_en_s;
                    cnt_d     = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    if (pend_en_q) begin
                        state_d  = ST_ON;
                        cur_id_d = pend_id_q;
                        sw_cnt_d = sw_cnt_q + 16'd1;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ON: begin
                if (valid_wr_s && !same_s) begin
                    pend_id_d = wr_id_s;
                    pend_en_d = wr_en_s;
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_GUARD;
                end else begin
                    state_d = ST_ON;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // State, bus response and registered enables.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_OFF;
            cur_id_q  <= 8'd0;
            pend_id_q <= 8'd0;
            pend_en_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            sw_cnt_q  <= 16'd0;
            ack_q     <= 1'b0;
            dat_q     <= 32'h0000_0000;
            active_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_id_q  <= cur_id_d;
            pend_id_q <= pend_id_d;
            pend_en_q <= pend_en_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            sw_cnt_q  <= sw_cnt_d;
            ack_q     <= hit_s & ~ack_q;
            dat_q     <= (hit_s & ~ack_q & ~wbs_we_i) ? rdata_s : 32'h0000_0000;
            active_q  <= (state_d == ST_ON) ? onehot_s : '0;
            busy_q    <= (state_d == ST_GUARD);
        end
    end

endmodule

// File: tb/tb_project_select_ctrl.sv
// Directed bench for project_select_ctrl with hand-computed expectations.
module tb_project_select_ctrl;

    logic        clk;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat_o;
    logic [2:0]  act;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] A_CTRL = 32'h3000_0000;
    localparam logic [31:0] A_STAT = 32'h3000_0004;

    project_select_ctrl dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat_o),
        .active    (act),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus transfer; holds the request through the ack cycle.
    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd,
                           output logic acked, output int ncyc);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
        acked = 1'b0; rd = 32'h0; ncyc = 0;
        for (int i = 1; i <= 4; i++) begin
            if (!acked) begin
                @(posedge clk); #1;
                if (ack) begin
                    acked = 1'b1; rd = rdat_o; ncyc = i;
                end
            end
        end
        if (acked) begin
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic ok; int n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
        n_cmp++; if (rdat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", rdat_o); end
        n_cmp++; if (act !== 3'b000) begin n_fail++; $display("FAIL reset_active: got %b want 000", act); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk); rst = 1'b0;
        wb_xfer(A_STAT, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (ok !== 1'b1 || n != 1) begin n_fail++; $display("FAIL reset_read_ack: acked %b after %0d want 1 after 1", ok, n); end
        n_cmp++; if (rd !== 32'h0000_0000) begin n_fail++; $display("FAIL reset_status: got %h want 00000000", rd); end
    endtask

    // Checks that all enables stay low with busy high for exactly 16 samples.
    task automatic test_select();
        logic [31:0] rd; logic ok; int n;
        wb_xfer(A_CTRL, 1'b1, 4'hF, 32'h8000_0001, rd, ok, n);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sel1_ack: got %b want 1", ok); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || act !== 3'b000) begin
                n_fail++; $display("FAIL sel1_guard[%0d]: busy %b active %b want 1 000", i, busy, act);
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (act !== 3'b010 || busy !== 1'b0) begin n_fail++; $display("FAIL sel1_on: active %b busy %b want 010 0", act, busy); end
        wb_xfer(A_STAT, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (rd !== 32'h0001_0101) begin n_fail++; $display("FAIL sel1_status: got %h want 00010101", rd); end
        wb_xfer(A_CTRL, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (rd !== 32'h8000_0001) begin n_fail++; $display("FAIL sel1_ctrl: got %h want 80000001", rd); end
    endtask

    task automatic test_switch();
        logic [31:0] rd; logic ok; int n;
        wb_xfer(A_CTRL, 1'b1, 4'hF, 32'h8000_0002, rd, ok, n);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || act !== 3'b000) begin
                n_fail++; $display("FAIL sw2_guard[%0d]: busy %b active %b want 1 000", i, busy, act);
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (act !== 3'b100) begin n_fail++; $display("FAIL sw2_on: got %b want 100", act); end
        wb_xfer(A_STAT, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (rd !== 32'h0002_0102) begin n_fail++; $display("FAIL sw2_status: got %h want 00020102", rd); end
        wb_xfer(A_CTRL, 1'b1, 4'hF, 32'h8000_0002, rd, ok, n);
        n_cmp++; if (busy !== 1'b0 || act !== 3'b100) begin n_fail++; $display("FAIL same_id_nop: busy %b active %b want 0 100", busy, act); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || act !== 3'b100) begin n_fail++; $display("FAIL same_id_hold: busy %b active %b want 0 100", busy, act); end
    endtask

    task automatic test_invalid_id();
        logic [31:0] rd; logic ok; int n; int w;
        wb_xfer(A_CTRL, 1'b1, 4'hF, 32'h8000_0005, rd, ok, n);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bad_id_ack: got %b want 1", ok); end
        n_cmp++; if (busy !== 1'b0 || act !== 3'b100) begin n_fail++; $display("FAIL bad_id_state: busy %b active %b want 0 100", busy, act); end
        wb_xfer(A_CTRL, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (rd !== 32'h8000_0002) begin n_fail++; $display("FAIL bad_id_pend: got %h want 80000002", rd); end
        wb_xfer(A_STAT, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (rd !== 32'h0002_0502) begin n_fail++; $display("FAIL bad_id_err: got %h want 00020502", rd); end
        wb_xfer(A_CTRL, 1'b1, 4'hF, 32'h0000_0000, rd, ok, n);
        n_cmp++; if (busy !== 1'b1 || act !== 3'b000) begin n_fail++; $display("FAIL off_guard: busy %b active %b want 1 000", busy, act); end
        wb_xfer(A_STAT, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (rd !== 32'h0002_0202) begin n_fail++; $display("FAIL off_guard_status: got %h want 00020202", rd); end
        w = 0;
        while (busy === 1'b1 && w < 30) begin
            @(posedge clk); #1; w++;
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL off_timeout: busy %b after %0d cycles want 0", busy, w); end
        n_cmp++; if (act !== 3'b000) begin n_fail++; $display("FAIL off_active: got %b want 000", act); end
        wb_xfer(A_STAT, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (rd !== 32'h0002_0002) begin n_fail++; $display("FAIL off_status: got %h want 00020002", rd); end
        wb_xfer(A_CTRL, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (rd !== 32'h0000_0000) begin n_fail++; $display("FAIL off_ctrl: got %h want 00000000", rd); end
    endtask

    task automatic test_guard_restart_and_reset();
        logic [31:0] rd; logic ok; int n;
        wb_xfer(A_CTRL, 1'b1, 4'hF, 32'h8000_0001, rd, ok, n);
        repeat (9) @(posedge clk);
        // Ack lands while the countdown sits at 5.
        wb_xfer(A_CTRL, 1'b1, 4'hF, 32'h8000_0000, rd, ok, n);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || act !== 3'b000) begin
                n_fail++; $display("FAIL restart_guard[%0d]: busy %b active %b want 1 000", i, busy, act);
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (act !== 3'b001 || busy !== 1'b0) begin n_fail++; $display("FAIL restart_on: active %b busy %b want 001 0", act, busy); end
        wb_xfer(A_STAT, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (rd !== 32'h0003_0100) begin n_fail++; $display("FAIL restart_status: got %h want 00030100", rd); end
        wb_xfer(A_CTRL, 1'b1, 4'hF, 32'h8000_0002, rd, ok, n);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (act !== 3'b000 || busy !== 1'b0 || ack !== 1'b0) begin
            n_fail++; $display("FAIL midguard_reset: active %b busy %b ack %b want 000 0 0", act, busy, ack);
        end
        @(negedge clk); rst = 1'b0;
        wb_xfer(A_STAT, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (rd !== 32'h0000_0000) begin n_fail++; $display("FAIL post_reset_status: got %h want 00000000", rd); end
        wb_xfer(A_CTRL, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (rd !== 32'h0000_0000) begin n_fail++; $display("FAIL post_reset_ctrl: got %h want 00000000", rd); end
        n_cmp++; if (busy !== 1'b0 || act !== 3'b000) begin n_fail++; $display("FAIL post_reset_idle: busy %b active %b want 0 000", busy, act); end
    endtask

    task automatic test_decode_and_ack();
        logic [31:0] rd; logic ok; int n;
        logic exp_ack;
        wb_xfer(32'h3000_0010, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (ok !== 1'b0) begin n_fail++; $display("FAIL out_of_window: acked %b want 0", ok); end
        wb_xfer(32'h3000_0008, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (ok !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL unused_offset: acked %b data %h want 1 00000000", ok, rd); end
        wb_xfer(A_CTRL, 1'b1, 4'h1, 32'h8000_0001, rd, ok, n);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL partial_ack: got %b want 1", ok); end
        n_cmp++; if (busy !== 1'b0 || act !== 3'b000) begin n_fail++; $display("FAIL partial_nop: busy %b active %b want 0 000", busy, act); end
        wb_xfer(A_CTRL, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (rd !== 32'h0000_0000) begin n_fail++; $display("FAIL partial_ctrl: got %h want 00000000", rd); end
        wb_xfer(A_STAT, 1'b1, 4'hF, 32'hFFFF_FFFF, rd, ok, n);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL status_write_ack: got %b want 1", ok); end
        wb_xfer(A_STAT, 1'b0, 4'hF, 32'h0, rd, ok, n);
        n_cmp++; if (rd !== 32'h0000_0000) begin n_fail++; $display("FAIL status_write_ignored: got %h want 00000000", rd); end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = A_STAT;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            exp_ack = (i % 2 == 0) ? 1'b1 : 1'b0;
            n_cmp++; if (ack !== exp_ack) begin n_fail++; $display("FAIL held_ack[%0d]: got %b want %b", i, ack, exp_ack); end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; adr = 32'h0;
    endtask

    initial begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        rst = 1'b1;
        test_reset();
        test_select();
        test_switch();
        test_invalid_id();
        test_guard_restart_and_reset();
        test_decode_and_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
